// File: rtl/gray_counter_param.sv
//------------------------------------------------------------------------------
// Module  : gray_counter_param
// Brief   : Parametrised up/down Gray counter with load, wrap/saturate mode,
//           terminal-count flag and sticky overflow. Optional overflow event
//           counter (port OvfCnt) enabled by defining GRAY_OVF_COUNT_EN.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gray_counter_param #(
  parameter int WIDTH         = 3,
  parameter int SATURATE      = 0,
  parameter int OVF_CNT_WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             OvfClr,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] counter,
  output logic             Overflow,
`ifdef GRAY_OVF_COUNT_EN
  output logic [OVF_CNT_WIDTH-1:0] OvfCnt,
`endif
  output logic             Tc
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  if (WIDTH < 2 || OVF_CNT_WIDTH < 1) begin : g_bad_params
    $error("gray_counter_param: WIDTH must be >= 2 and OVF_CNT_WIDTH >= 1");
  end

  logic             w_terminal;
  logic             w_ovf_evt;
  logic [WIDTH-1:0] w_next;

  assign w_terminal = Dir ? (counter == '1) : (counter == '0);
  assign Tc         = w_terminal;

  // A terminal step in wrap mode is just the ordinary modulo step.
  always_comb begin
    w_next    = counter;
    w_ovf_evt = 1'b0;
    if (Load) begin
      w_next = LoadVal;
    end else if (En) begin
      w_ovf_evt = w_terminal;
      if (!(w_terminal && (SATURATE != 0))) begin
        w_next = Dir ? (counter + c_one) : (counter - c_one);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      counter  <= '0;
      Output   <= '0;
      Overflow <= 1'b0;
    end else begin
      counter <= w_next;
      Output  <= w_next ^ (w_next >> 1);
      if (w_ovf_evt) begin
        Overflow <= 1'b1;
      end else if (OvfClr) begin
        Overflow <= 1'b0;
      end
    end
  end

`ifdef GRAY_OVF_COUNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      OvfCnt <= '0;
    end else if (w_ovf_evt) begin
      if (OvfClr) begin
        OvfCnt <= OVF_CNT_WIDTH'(1);
      end else if (OvfCnt != '1) begin
        OvfCnt <= OvfCnt + OVF_CNT_WIDTH'(1);
      end
    end else if (OvfClr) begin
      OvfCnt <= '0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/gray_counter_param.md
Name: gray_counter_param

Overview:
- Parametrised successor of the team's fixed 3-bit Gray counter.
- Generalises width; adds up/down counting, synchronous load, wrap or saturate mode, a terminal-count flag and a clearable sticky overflow.
- Used as a generic sequence/pointer generator where single-bit-change outputs are required; exposes both the Gray code and the binary count.

Parameters:
- WIDTH, 3, counter width in bits (>=2).
- SATURATE, 0, 0 = wrap at terminal value, 1 = hold at terminal value.
- OVF_CNT_WIDTH, 4, width of overflow event counter (used only with the optional feature).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous active-high reset.
- En  input  1  count enable; one step per enabled cycle.
- Dir  input  1  1 = count up, 0 = count down; sampled only when En=1.
- Load  input  1  synchronous load of LoadVal.
- LoadVal  input  WIDTH  binary value to load.
- OvfClr  input  1  clears sticky Overflow.
- Output  output  WIDTH  Gray code of counter, registered.
- counter  output  WIDTH  binary count, registered.
- Overflow  output  1  sticky wrap/saturation flag.
- Tc  output  1  terminal-count indicator for the current direction.

Behaviour:
- Single clock domain; all state updates on rising edge of Clk. Reset is synchronous, active-high.
- Reset values: counter=0, Output=0, Overflow=0, OvfCnt=0.
- Update priority per edge: Reset > Load > En. Lower-priority actions are ignored that cycle.
- Load=1: counter<=LoadVal; Output<=LoadVal^(LoadVal>>1); Overflow unchanged; no overflow event.
- En=1, Dir=1, counter!=2^WIDTH-1: counter<=counter+1.
- En=1, Dir=0, counter!=0: counter<=counter-1.
- Terminal step (En=1; up at 2^WIDTH-1 or down at 0):
  - SATURATE=0: counter wraps (to 0 up, to 2^WIDTH-1 down).
  - SATURATE=1: counter holds its value.
  - Either mode: Overflow<=1 and an overflow event is raised.
- En=0: counter holds.
- Output always equals Gray(counter) in the same cycle, registered (computed from next binary value). No combinational path from inputs to Output.
- Consecutive enabled steps change exactly one Output bit, including across a wrap. A Load may change several bits.
- Tc is combinational from registered state and Dir: Tc=1 when (Dir=1 and counter=2^WIDTH-1) or (Dir=0 and counter=0). Tc does not depend on En.
- Overflow is sticky. Cleared by Reset or OvfClr. If OvfClr and an overflow event occur in the same cycle, set wins (Overflow=1).
- Dir may change any cycle; it takes effect on the next enabled edge.
- Reset asserted mid-count clears all state on that edge, regardless of En/Load.
- All arithmetic is WIDTH bits, modulo 2^WIDTH.

Optional Feature:
- Macro: GRAY_OVF_COUNT_EN.
- Defined:
  - Adds output port OvfCnt [OVF_CNT_WIDTH-1:0], reset 0.
  - Increments by 1 on each overflow event and saturates at 2^OVF_CNT_WIDTH-1.
  - Cleared by OvfClr unless an overflow event occurs the same cycle; then OvfCnt<=1.
- Not defined: port and logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=3, SATURATE=0, Reset then En=1, Dir=1 for 8 edges -> Output 001,011,010,110,111,101,100,000; Overflow goes 1 on the 8th edge; Tc=1 while counter=7.
- Dir=0 from counter=0, En=1, one edge -> counter=7, Output=100, Overflow=1; next edge -> counter=6, Output=101.
- SATURATE=1, up from counter=6, En=1 for 3 edges -> counter 7,7,7; Output stays 100; Overflow=1 from the 2nd edge.
- Load=1, LoadVal=5, with En=1 same cycle -> counter=5, Output=111, no step; then OvfClr=1 with a terminal step in the same cycle -> Overflow remains 1.
- Reset=1 mid-count at counter=4 with En=1 and Load=1 -> next edge: counter=0, Output=000, Overflow=0, OvfCnt=0.
- GRAY_OVF_COUNT_EN, OVF_CNT_WIDTH=2, 5 wraps -> OvfCnt 1,2,3,3,3; OvfClr alone -> 0.
